// File: rtl/nn_weight_loader.sv
// Neuron weight/bias configuration bus driver: unpacks host record stream.
// Optional CFG_CHECKSUM_EN adds a trailing load checksum word (CHK state).
module nn_weight_loader #(
    parameter int NUM_RECORDS = 32,
    parameter int MAX_WEIGHTS = 1024,
    parameter int CNT_W       = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        weightValid,
    output logic [31:0] weightValue,
    output logic        biasValid,
    output logic [31:0] biasValue,
    output logic [31:0] config_layer_num,
    output logic [31:0] config_neuron_num,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int RW = $clog2(NUM_RECORDS) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_WGT,
        S_BIAS,
        S_DRAIN,
`ifdef CFG_CHECKSUM_EN
        S_CHK,
`endif
        S_END
    } state_t;

    state_t           state;
    state_t           next_state;
    state_t           exit_state;
    logic [CNT_W-1:0] wcnt;
    logic [CNT_W:0]   dcnt;
    logic [RW-1:0]    rec_cnt;
    logic             xfer;
    logic [CNT_W-1:0] hdr_n;
    logic             hdr_ok;
    logic             last_rec;
    logic             rec_end;
`ifdef CFG_CHECKSUM_EN
    logic [31:0]      sum;
`endif

    assign xfer     = s_valid & s_ready;
    assign hdr_n    = s_data[CNT_W-1:0];
    assign hdr_ok   = (hdr_n != '0) && (32'(hdr_n) <= 32'(MAX_WEIGHTS));
    assign last_rec = rec_cnt == RW'(NUM_RECORDS - 1);
    assign rec_end  = xfer && ((state == S_BIAS) ||
                      (state == S_DRAIN && dcnt == (CNT_W+1)'(1)));

`ifdef CFG_CHECKSUM_EN
    assign exit_state = last_rec ? S_CHK : S_HDR;
`else
    assign exit_state = last_rec ? S_END : S_HDR;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE:  if (start) next_state = S_HDR;
            S_HDR:   if (xfer) next_state = hdr_ok ? S_WGT : S_DRAIN;
            S_WGT:   if (xfer && wcnt == CNT_W'(1)) next_state = S_BIAS;
            S_BIAS:  if (xfer) next_state = exit_state;
            S_DRAIN: if (rec_end) next_state = exit_state;
`ifdef CFG_CHECKSUM_EN
            S_CHK:   if (xfer) next_state = S_END;
`endif
            S_END:   next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        s_ready = 1'b0;
        busy    = 1'b0;
        unique case (state)
            S_IDLE:  ;
            S_END:   busy = 1'b1;
            default: begin
                s_ready = 1'b1;
                busy    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            weightValid       <= 1'b0;
            weightValue       <= '0;
            biasValid         <= 1'b0;
            biasValue         <= '0;
            config_layer_num  <= '0;
            config_neuron_num <= '0;
            done              <= 1'b0;
            err               <= 1'b0;
            wcnt              <= '0;
            dcnt              <= '0;
            rec_cnt           <= '0;
        end else begin
            weightValid <= xfer && state == S_WGT;
            biasValid   <= xfer && state == S_BIAS;
            done        <= state == S_END;
            if (state == S_IDLE && start) begin
                err     <= 1'b0;
                rec_cnt <= '0;
            end
            if (xfer && state == S_WGT) begin
                weightValue <= s_data;
                wcnt        <= wcnt - CNT_W'(1);
            end
            if (xfer && state == S_BIAS)
                biasValue <= s_data;
            if (xfer && state == S_DRAIN)
                dcnt <= dcnt - (CNT_W+1)'(1);
            if (xfer && state == S_HDR) begin
                if (hdr_ok) begin
                    config_layer_num  <= {24'd0, s_data[31:24]};
                    config_neuron_num <= {24'd0, s_data[23:16]};
                    wcnt              <= hdr_n;
                end else begin
                    // Malformed record: swallow its N words plus the bias
                    err  <= 1'b1;
                    dcnt <= (CNT_W+1)'(hdr_n) + (CNT_W+1)'(1);
                end
            end
            if (rec_end)
                rec_cnt <= rec_cnt + RW'(1);
`ifdef CFG_CHECKSUM_EN
            if (xfer && state == S_CHK && s_data != sum)
                err <= 1'b1;
`endif
        end
    end

`ifdef CFG_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sum <= '0;
        else if (state == S_IDLE && start)
            sum <= '0;
        else if (xfer && state != S_CHK)
            sum <= sum + s_data;
    end
`endif

endmodule

// File: tb/tb_nn_weight_loader.sv
// Directed bench for nn_weight_loader with NUM_RECORDS=2.
// Records observed bus events and compares them to hand-built expectations.
module tb_nn_weight_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        weightValid;
    logic [31:0] weightValue;
    logic        biasValid;
    logic [31:0] biasValue;
    logic [31:0] config_layer_num;
    logic [31:0] config_neuron_num;
    logic        busy;
    logic        done;
    logic        err;

    int pass_cnt = 0;
    int total    = 0;

    logic [63:0] ev [$];
    logic [63:0] exp_ev [$];
    logic [31:0] words [$];
    int          done_cnt = 0;
    int          stray = 0;
    logic        busy_at_done = 1'b0;
    logic        acc_prev = 1'b0;
`ifdef CFG_CHECKSUM_EN
    int          sum_bias = 0;
`endif

    nn_weight_loader #(.NUM_RECORDS(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .weightValid(weightValid), .weightValue(weightValue),
        .biasValid(biasValid), .biasValue(biasValue),
        .config_layer_num(config_layer_num),
        .config_neuron_num(config_neuron_num),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ew(input logic [7:0] l, input logic [7:0] n,
                                       input logic [31:0] v);
        return {8'h57, l, n, v};
    endfunction

    function automatic logic [63:0] eb(input logic [7:0] l, input logic [7:0] n,
                                       input logic [31:0] v);
        return {8'h42, l, n, v};
    endfunction

    always @(posedge clk) acc_prev <= s_valid && s_ready;

    always @(negedge clk) begin
        logic hi;
        hi = (|config_layer_num[31:8]) | (|config_neuron_num[31:8]);
        if (weightValid)
            ev.push_back({hi, 7'h57, config_layer_num[7:0],
                          config_neuron_num[7:0], weightValue});
        if (biasValid)
            ev.push_back({hi, 7'h42, config_layer_num[7:0],
                          config_neuron_num[7:0], biasValue});
        if ((weightValid || biasValid) && !acc_prev)
            stray++;
        if (done) begin
            done_cnt++;
            busy_at_done = busy;
        end
    end

    task automatic send_word(input logic [31:0] w, input bit gap);
        bit ok;
        ok = 0;
        s_data  = w;
        s_valid = 1'b1;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            if (s_ready) begin
                @(posedge clk);
                #1;
                ok = 1;
            end
        end
        s_valid = 1'b0;
        if (!ok) begin
            total++;
            $display("FAIL send_word: word %h not accepted, s_ready=%b required 1",
                     w, s_ready);
        end
        if (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic do_load(input bit gap, input int start_at);
        logic [31:0] sum;
        sum = '0;
        ev.delete();
        done_cnt = 0;
        stray    = 0;
        pulse_start();
        foreach (words[i]) begin
            if (i == start_at) pulse_start();
            send_word(words[i], gap);
            sum += words[i];
        end
`ifdef CFG_CHECKSUM_EN
        send_word(sum + 32'(sum_bias), gap);
`endif
        for (int c = 0; c < 40 && done_cnt == 0; c++)
            @(negedge clk);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_load(input string name, input logic exp_err);
        total++;
        if (ev.size() !== exp_ev.size())
            $display("FAIL %s_count: got %0d events, required %0d",
                     name, ev.size(), exp_ev.size());
        else pass_cnt++;
        for (int i = 0; i < exp_ev.size() && i < ev.size(); i++) begin
            total++;
            if (ev[i] !== exp_ev[i])
                $display("FAIL %s_ev%0d: got %h required %h",
                         name, i, ev[i], exp_ev[i]);
            else pass_cnt++;
        end
        total++;
        if (done_cnt !== 1)
            $display("FAIL %s_done: got %0d pulses required 1", name, done_cnt);
        else pass_cnt++;
        total++;
        if (busy_at_done !== 1'b0)
            $display("FAIL %s_busy_at_done: got %b required 0", name, busy_at_done);
        else pass_cnt++;
        total++;
        if (err !== exp_err)
            $display("FAIL %s_err: got %b required %b", name, err, exp_err);
        else pass_cnt++;
        total++;
        if (stray !== 0)
            $display("FAIL %s_stray: got %0d unaccepted pulses required 0",
                     name, stray);
        else pass_cnt++;
    endtask

    task automatic load_basic_stream();
        words  = '{32'h0100_0003, 32'd1, 32'd2, 32'd3, 32'd9,
                   32'h0201_0001, 32'hFFFF_FFFB, 32'd7};
        exp_ev = '{ew(1, 0, 1), ew(1, 0, 2), ew(1, 0, 3), eb(1, 0, 9),
                   ew(2, 1, 32'hFFFF_FFFB), eb(2, 1, 7)};
    endtask

    task automatic test_reset();
        logic [31:0] got;
        got = {24'd0, s_ready, weightValid, biasValid, busy, done, err,
               |config_layer_num, |config_neuron_num};
        total++;
        if (got !== 32'd0 || weightValue !== 0 || biasValue !== 0)
            $display("FAIL reset_outputs: got %h/%h/%h required 0/0/0",
                     got, weightValue, biasValue);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        load_basic_stream();
        do_load(1'b0, -1);
        check_load("basic", 1'b0);
    endtask

    task automatic test_gaps();
        load_basic_stream();
        do_load(1'b1, -1);
        check_load("gaps", 1'b0);
    endtask

    task automatic test_drain();
        words  = '{32'h0500_0000, 32'h0000_DEAD, 32'h0102_0002,
                   32'd10, 32'd20, 32'd30};
        exp_ev = '{ew(1, 2, 10), ew(1, 2, 20), eb(1, 2, 30)};
        do_load(1'b0, -1);
        check_load("drain", 1'b1);
    endtask

    task automatic test_start_busy();
        ev.delete();
        stray   = 0;
        s_data  = 32'h0100_0003;
        s_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (s_ready !== 1'b0 || busy !== 1'b0)
                $display("FAIL idle_ready%0d: s_ready=%b busy=%b required 0/0",
                         c, s_ready, busy);
            else pass_cnt++;
        end
        s_valid = 1'b0;
        @(negedge clk);
        total++;
        if (ev.size() !== 0)
            $display("FAIL idle_accept: got %0d events required 0", ev.size());
        else pass_cnt++;
        load_basic_stream();
        do_load(1'b0, 3);
        check_load("start_busy", 1'b0);
    endtask

    task automatic test_midreset();
        ev.delete();
        pulse_start();
        send_word(32'h0100_0003, 1'b0);
        send_word(32'd1, 1'b0);
        send_word(32'd2, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({weightValid, biasValid, busy, done, err, s_ready} !== 6'd0 ||
            weightValue !== 0 || config_layer_num !== 0)
            $display("FAIL midreset_async: wv=%b busy=%b rdy=%b wval=%h layer=%h required all 0",
                     weightValid, busy, s_ready, weightValue, config_layer_num);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        load_basic_stream();
        do_load(1'b0, -1);
        check_load("reload", 1'b0);
    endtask

`ifdef CFG_CHECKSUM_EN
    task automatic test_checksum();
        load_basic_stream();
        sum_bias = 0;
        do_load(1'b0, -1);
        check_load("chk_good", 1'b0);
        sum_bias = 1;
        do_load(1'b0, -1);
        check_load("chk_bad", 1'b1);
        sum_bias = 0;
    endtask
`endif

    initial begin
        #12;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_basic();
        test_gaps();
        test_drain();
        test_start_busy();
        test_midreset();
`ifdef CFG_CHECKSUM_EN
        test_checksum();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
